// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready register request into one APB transfer
// (SETUP -> ACCESS) and returns a valid/ready response. One transfer in flight.
// An optional access-phase timeout aborts a transfer the completer never readies.
module apb_initiator #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 256,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [ADDR_W-1:0]   apb_paddr,
  output logic [DATA_W-1:0]   apb_pwdata,
  input  logic                apb_pready,
  input  logic [DATA_W-1:0]   apb_prdata,
  input  logic                apb_pslverr,
  output logic [ERRCNT_W-1:0] err_count
);

  // Counter holds 0..TIMEOUT; keep at least one bit when the timeout is disabled.
  localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
  logic                  timeout_hit;

  // Abort only on the last allowed ACCESS cycle; pready in that same cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_W'(TLIM));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake and APB phase strobes
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = 1'b1;
      SETUP:   apb_psel  = 1'b1;
      ACCESS:  begin apb_psel = 1'b1; apb_penable = 1'b1; end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: capture request, capture completion, count errors
  always_comb begin
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    tcnt_d   = tcnt_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        addr_d  = req_addr;
        wdata_d = req_write ? req_wdata : '0;  // pwdata reads as 0 on reads
        tcnt_d  = '0;
      end
      ACCESS: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
        if (apb_pready) begin
          rdata_d = write_q ? '0 : apb_prdata;
          err_d   = apb_pslverr;
          tmo_d   = 1'b0;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      RESP: if (rsp_ready && err_q && (errcnt_q != '1)) errcnt_d = errcnt_q + ERRCNT_W'(1);
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      tcnt_q   <= '0;
      errcnt_q <= '0;
    end else begin
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
      errcnt_q <= errcnt_d;
    end
  end

  // APB address/data only change when a request is captured, so they stay put
  // through SETUP and ACCESS.
  assign apb_pwrite  = write_q;
  assign apb_paddr   = addr_q;
  assign apb_pwdata  = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign err_count   = errcnt_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator (TIMEOUT=4, 2-bit error counter).
module tb_apb_initiator;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          apb_psel, apb_penable, apb_pwrite;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_pwdata;
  logic          apb_pready, apb_pslverr;
  logic [DW-1:0] apb_prdata;
  logic [EW-1:0] err_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .ERRCNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
    .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr),
    .err_count(err_count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    apb_pready = 0; apb_prdata = '0; apb_pslverr = 0;
    rst_n = 0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if ({req_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, rsp_err, rsp_timeout} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, rsp_valid, apb_psel, apb_penable, apb_pwrite, rsp_err, rsp_timeout}); end
    n_chk++; if ({apb_paddr, apb_pwdata, rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h want 0", apb_paddr, apb_pwdata, rsp_rdata); end
    n_chk++; if (err_count !== 2'd0) begin
      n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
    @(negedge clk); rst_n = 1;
    tick();
    n_chk++; if ({req_ready, apb_psel} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: got %b want 10", {req_ready, apb_psel}); end
  endtask

  task automatic test_write();
    req_valid = 1; req_write = 1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF;
    apb_pready = 1; apb_prdata = 32'h55AA_55AA; apb_pslverr = 0;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b want 1", req_ready); end
    tick(); req_valid = 0;  // cycle N+1: SETUP
    n_chk++; if ({req_ready, apb_psel, apb_penable, apb_pwrite, rsp_valid} !== 5'b01010) begin
      n_fail++; $display("FAIL wr_setup: got %b want 01010", {req_ready, apb_psel, apb_penable, apb_pwrite, rsp_valid}); end
    n_chk++; if ({apb_paddr, apb_pwdata} !== {32'h0000_0010, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wr_setup_bus: got %h %h want 00000010 deadbeef", apb_paddr, apb_pwdata); end
    tick();  // N+2: ACCESS
    n_chk++; if ({apb_psel, apb_penable, rsp_valid} !== 3'b110) begin
      n_fail++; $display("FAIL wr_access: got %b want 110", {apb_psel, apb_penable, rsp_valid}); end
    tick();  // N+3: RESP
    n_chk++; if ({rsp_valid, rsp_err, rsp_timeout, apb_psel, apb_penable, req_ready} !== 6'b100000) begin
      n_fail++; $display("FAIL wr_resp: got %b want 100000", {rsp_valid, rsp_err, rsp_timeout, apb_psel, apb_penable, req_ready}); end
    n_chk++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata); end
    rsp_ready = 1; tick(); rsp_ready = 0; apb_pready = 0;
    n_chk++; if ({rsp_valid, req_ready, err_count} !== 4'b0100) begin
      n_fail++; $display("FAIL wr_done: got %b want 0100", {rsp_valid, req_ready, err_count}); end
  endtask

  task automatic test_read_wait();
    req_valid = 1; req_write = 0; req_addr = 32'h0100_0004; req_wdata = 32'hFFFF_FFFF;
    tick(); req_valid = 0;  // SETUP; pready here must be ignored
    apb_pready = 1; apb_prdata = 32'hBAD0_BAD0;
    n_chk++; if ({apb_psel, apb_penable, apb_pwrite, apb_pwdata} !== {3'b100, 32'h0}) begin
      n_fail++; $display("FAIL rd_setup: got %b %h want 100 0", {apb_psel, apb_penable, apb_pwrite}, apb_pwdata); end
    tick();
    for (int i = 0; i < 4; i++) begin
      apb_pready = (i == 3); apb_prdata = (i == 3) ? 32'h1234_5678 : 32'hBAD0_BAD0;
      n_chk++; if ({apb_psel, apb_penable, rsp_valid, apb_paddr} !== {3'b110, 32'h0100_0004}) begin
        n_fail++; $display("FAIL rd_access%0d: got %b %h want 110 01000004", i, {apb_psel, apb_penable, rsp_valid}, apb_paddr); end
      tick();
    end
    apb_pready = 0;
    n_chk++; if ({rsp_valid, rsp_err, rsp_timeout, apb_psel} !== 4'b1000) begin
      n_fail++; $display("FAIL rd_resp: got %b want 1000", {rsp_valid, rsp_err, rsp_timeout, apb_psel}); end
    n_chk++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata); end
    rsp_ready = 1; tick(); rsp_ready = 0;
  endtask

  task automatic test_slverr_hold();
    req_valid = 1; req_write = 0; req_addr = 32'h0000_0020;
    apb_pready = 1; apb_pslverr = 1; apb_prdata = 32'hCAFE_0001;
    tick(); req_valid = 0;
    tick(); tick();  // RESP
    apb_pslverr = 0; apb_prdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if ({rsp_valid, rsp_err, rsp_timeout, req_ready, rsp_rdata, err_count} !== {4'b1100, 32'hCAFE_0001, 2'd0}) begin
        n_fail++; $display("FAIL err_hold%0d: got %b %h %0d want 1100 cafe0001 0", i, {rsp_valid, rsp_err, rsp_timeout, req_ready}, rsp_rdata, err_count); end
      if (i < 5) tick();
    end
    rsp_ready = 1; tick(); rsp_ready = 0; apb_pready = 0;
    n_chk++; if ({rsp_valid, err_count} !== 3'b001) begin
      n_fail++; $display("FAIL err_count_inc: got %b want 001", {rsp_valid, err_count}); end
  endtask

  task automatic test_timeout();
    req_valid = 1; req_write = 0; req_addr = 32'h0000_0030; apb_pready = 0;
    tick(); req_valid = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({apb_psel, apb_penable, rsp_valid} !== 3'b110) begin
        n_fail++; $display("FAIL tmo_access%0d: got %b want 110", i, {apb_psel, apb_penable, rsp_valid}); end
      tick();
    end
    apb_pready = 1; apb_prdata = 32'hFFFF_0000;  // late pready
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({apb_psel, apb_penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00111, 32'h0}) begin
        n_fail++; $display("FAIL tmo_resp%0d: got %b %h want 00111 0", i, {apb_psel, apb_penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
      if (i < 2) tick();
    end
    rsp_ready = 1; tick(); rsp_ready = 0; apb_pready = 0;
    n_chk++; if ({rsp_valid, req_ready, err_count} !== 4'b0110) begin
      n_fail++; $display("FAIL tmo_done: got %b want 0110", {rsp_valid, req_ready, err_count}); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    logic [3:0]    exp_ctl [4];  // {req_ready, psel, penable, rsp_valid} per phase
    int k, ph;
    addrs = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    datas = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    exp_ctl = '{4'b1000, 4'b0100, 4'b0110, 4'b0001};
    apb_pready = 1; apb_pslverr = 0; rsp_ready = 1; req_valid = 1; req_write = 0;
    for (int c = 0; c < 12; c++) begin
      k = c / 4; ph = c % 4;
      if (ph == 0) req_addr = addrs[k];
      if (ph == 2) apb_prdata = datas[k];
      n_chk++; if ({req_ready, apb_psel, apb_penable, rsp_valid} !== exp_ctl[ph]) begin
        n_fail++; $display("FAIL b2b_ctl c%0d: got %b want %b", c, {req_ready, apb_psel, apb_penable, rsp_valid}, exp_ctl[ph]); end
      if (ph == 1) begin
        n_chk++; if (apb_paddr !== addrs[k]) begin n_fail++; $display("FAIL b2b_addr%0d: got %h want %h", k, apb_paddr, addrs[k]); end
      end
      if (ph == 3) begin
        n_chk++; if (rsp_rdata !== datas[k]) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", k, rsp_rdata, datas[k]); end
        if (k == 2) req_valid = 0;
      end
      tick();
    end
    rsp_ready = 0; apb_pready = 0;
    n_chk++; if ({req_ready, apb_psel, err_count} !== 4'b1010) begin
      n_fail++; $display("FAIL b2b_end: got %b want 1010", {req_ready, apb_psel, err_count}); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_write = 1; req_addr = 32'h0000_0040; req_wdata = 32'h0BAD_F00D; apb_pready = 0;
    tick(); req_valid = 0;
    tick();
    n_chk++; if ({apb_psel, apb_penable} !== 2'b11) begin n_fail++; $display("FAIL rst_pre: got %b want 11", {apb_psel, apb_penable}); end
    #2 rst_n = 0; #1;
    n_chk++; if ({apb_psel, apb_penable, rsp_valid, req_ready, err_count} !== 6'b000100) begin
      n_fail++; $display("FAIL rst_async: got %b want 000100", {apb_psel, apb_penable, rsp_valid, req_ready, err_count}); end
    n_chk++; if ({apb_paddr, apb_pwdata} !== '0) begin n_fail++; $display("FAIL rst_regs: got %h %h want 0", apb_paddr, apb_pwdata); end
    @(negedge clk); rst_n = 1; apb_pready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({req_ready, apb_psel, rsp_valid} !== 3'b100) begin
        n_fail++; $display("FAIL rst_after%0d: got %b want 100", i, {req_ready, apb_psel, rsp_valid}); end
    end
    apb_pready = 0;
  endtask

  // Runs one read that the completer flags with pslverr; no checks beyond a bounded wait.
  task automatic do_err_xfer(input logic [AW-1:0] a);
    req_valid = 1; req_write = 0; req_addr = a; apb_pready = 1; apb_pslverr = 1; apb_prdata = '0;
    tick(); req_valid = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_wait: got %b want 1", rsp_valid); end
    rsp_ready = 1; tick(); rsp_ready = 0; apb_pready = 0; apb_pslverr = 0;
  endtask

  task automatic test_err_saturate();
    logic [EW-1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      do_err_xfer(32'h0000_0100 + 32'(k));
      n_chk++; if (err_count !== exp_cnt[k]) begin
        n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", k, err_count, exp_cnt[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr_hold();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
